// File: rtl/tmc_status_conditioner.sv
// tmc_status_conditioner
// Conditions the eight external TMC status lines for the Nios II input PIO.
// Each raw line is synchronized into clk, debounced independently, and
// presented as a clean level together with one-cycle rise/fall pulses and a
// single change strobe covering all bits.

module tmc_status_conditioner #(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DEBOUNCE_CNT = 1000,
    parameter int               CNT_W        = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    // Counter value at which a differing level has held long enough.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt        [WIDTH];
    logic [CNT_W-1:0] cnt_next   [WIDTH];
    logic [WIDTH-1:0] clean_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Plain flop chain per bit; nothing sits between stages so the
    // metastability settling time is not eaten by logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= RESET_VALUE;
            end
        end else begin
            sync_chain[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    // Per-bit qualification: any cycle where the synchronized level agrees
    // with the accepted level restarts the count, so only an unbroken run of
    // DEBOUNCE_CNT differing cycles is accepted. The counter is cleared on
    // acceptance and therefore never needs to wrap.
    always_comb begin
        clean_next = clean_out;
        rise_next  = '0;
        fall_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync[i] == clean_out[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                clean_next[i] = sync[i];
                rise_next[i]  = sync[i];
                fall_next[i]  = ~sync[i];
                cnt_next[i]   = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounce counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Registered level and edge outputs, so no raw_in path reaches a port
    // and the pulses coincide with the cycle the new level first appears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean_out  <= RESET_VALUE;
            rise_pulse <= '0;
            fall_pulse <= '0;
            changed    <= 1'b0;
        end else begin
            clean_out  <= clean_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            changed    <= |{rise_next, fall_next};
        end
    end

endmodule

// File: tb/tb_tmc_status_conditioner.sv
// Testbench for tmc_status_conditioner (SYNC_STAGES=2, DEBOUNCE_CNT=4).
// The reference model keeps a history of raw_in samples and accepts a new
// level for a bit when the last DEBOUNCE_CNT synchronized samples all differ
// from the currently accepted level.

module tb_tmc_status_conditioner;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         changed;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] rawq [$];
    logic [W-1:0] exp_clean;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    logic         exp_changed;

    tmc_status_conditioner #(
        .WIDTH        (W),
        .SYNC_STAGES  (S),
        .DEBOUNCE_CNT (D),
        .CNT_W        (16),
        .RESET_VALUE  (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .changed    (changed)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Model history before any post-reset sample is the reset level.
    task automatic model_reset();
        rawq.delete();
        for (int j = 0; j < S + D; j++) rawq.push_back(8'h00);
        exp_clean   = 8'h00;
        exp_rise    = 8'h00;
        exp_fall    = 8'h00;
        exp_changed = 1'b0;
    endtask

    // Advance one clock: sample raw_in at the rising edge, update the model,
    // and return at the following falling edge for checking.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            rawq.push_back(raw_in);
            exp_rise = 8'h00;
            exp_fall = 8'h00;
            for (int i = 0; i < W; i++) begin
                logic         all_diff;
                logic [W-1:0] smp;
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    smp = rawq[rawq.size() - 1 - S - j];
                    if (smp[i] == exp_clean[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (exp_clean[i]) exp_fall[i] = 1'b1;
                    else              exp_rise[i] = 1'b1;
                    exp_clean[i] = ~exp_clean[i];
                end
            end
            exp_changed = |{exp_rise, exp_fall};
            while (rawq.size() > S + D) void'(rawq.pop_front());
        end
        @(negedge clk);
    endtask

    // Hold reset for two cycles with the given raw level, release on a falling edge.
    task automatic do_reset(input logic [W-1:0] v);
        reset_n = 1'b0;
        raw_in  = v;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        raw_in  = 8'hFF;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({clean_out, rise_pulse, fall_pulse, changed} !== 25'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold got clean=%h rise=%h fall=%h chg=%b required all zero",
                     clean_out, rise_pulse, fall_pulse, changed);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                miscompares++;
                $display("[TB] FAIL reset_model E%0d got %h/%h/%h/%b required %h/%h/%h/%b", n,
                         clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
            end
            if (n == 5) begin
                vectors++;
                if (clean_out !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL reset_early E5 got clean=%h required 00", clean_out);
                end
            end
            if (n == 6) begin
                vectors++;
                if ({clean_out, rise_pulse, changed} !== {8'hFF, 8'hFF, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL reset_release E6 got clean=%h rise=%h chg=%b required FF/FF/1",
                             clean_out, rise_pulse, changed);
                end
            end
            if (n == 7) begin
                vectors++;
                if ({clean_out, rise_pulse, changed} !== {8'hFF, 8'h00, 1'b0}) begin
                    miscompares++;
                    $display("[TB] FAIL reset_pulse_width E7 got clean=%h rise=%h chg=%b required FF/00/0",
                             clean_out, rise_pulse, changed);
                end
            end
        end
    endtask

    task automatic test_clean_step();
        do_reset(8'h00);
        repeat (2) tick();
        for (int phase = 0; phase < 2; phase++) begin
            raw_in = (phase == 0) ? 8'h08 : 8'h00;
            for (int n = 1; n <= 8; n++) begin
                tick();
                vectors++;
                if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                    miscompares++;
                    $display("[TB] FAIL step_model ph%0d E%0d got %h/%h/%h/%b required %h/%h/%h/%b", phase, n,
                             clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
                end
                if (n == 6) begin
                    vectors++;
                    if (phase == 0 && {clean_out, rise_pulse, fall_pulse} !== {8'h08, 8'h08, 8'h00}) begin
                        miscompares++;
                        $display("[TB] FAIL step_rise E6 got clean=%h rise=%h fall=%h required 08/08/00",
                                 clean_out, rise_pulse, fall_pulse);
                    end
                    if (phase == 1 && {clean_out, rise_pulse, fall_pulse} !== {8'h00, 8'h00, 8'h08}) begin
                        miscompares++;
                        $display("[TB] FAIL step_fall E6 got clean=%h rise=%h fall=%h required 00/00/08",
                                 clean_out, rise_pulse, fall_pulse);
                    end
                end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(8'h00);
        for (int n = 1; n <= 10; n++) begin
            raw_in = (n <= 3) ? 8'h20 : 8'h00;
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== 25'h0) begin
                miscompares++;
                $display("[TB] FAIL glitch_reject E%0d got %h/%h/%h/%b required all zero", n,
                         clean_out, rise_pulse, fall_pulse, changed);
            end
        end
        for (int n = 1; n <= 12; n++) begin
            raw_in = (n <= 4) ? 8'h20 : 8'h00;
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                miscompares++;
                $display("[TB] FAIL glitch_model E%0d got %h/%h/%h/%b required %h/%h/%h/%b", n,
                         clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
            end
            if (n == 6) begin
                vectors++;
                if ({clean_out, rise_pulse} !== {8'h20, 8'h20}) begin
                    miscompares++;
                    $display("[TB] FAIL glitch_pass E6 got clean=%h rise=%h required 20/20", clean_out, rise_pulse);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b1111_0111;
        do_reset(8'h00);
        for (int n = 1; n <= 14; n++) begin
            raw_in = (n <= 8) ? {7'h0, pat[n-1]} : 8'h01;
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                miscompares++;
                $display("[TB] FAIL bounce_model E%0d got %h/%h/%h/%b required %h/%h/%h/%b", n,
                         clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
            end
            if (n == 9) begin
                vectors++;
                if (clean_out !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL bounce_early E9 got clean=%h required 00", clean_out);
                end
            end
            if (n == 10) begin
                vectors++;
                if ({clean_out, rise_pulse} !== {8'h01, 8'h01}) begin
                    miscompares++;
                    $display("[TB] FAIL bounce_rise E10 got clean=%h rise=%h required 01/01", clean_out, rise_pulse);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset(8'h00);
        raw_in = 8'h0F;
        repeat (8) tick();
        vectors++;
        if (clean_out !== 8'h0F) begin
            miscompares++;
            $display("[TB] FAIL simul_setup got clean=%h required 0F", clean_out);
        end
        raw_in = 8'hF0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                miscompares++;
                $display("[TB] FAIL simul_model E%0d got %h/%h/%h/%b required %h/%h/%h/%b", n,
                         clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
            end
            if (n == 6) begin
                vectors++;
                if ({clean_out, rise_pulse, fall_pulse, changed} !== {8'hF0, 8'hF0, 8'h0F, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL simul_edge E6 got %h/%h/%h/%b required F0/F0/0F/1",
                             clean_out, rise_pulse, fall_pulse, changed);
                end
            end
            if (n == 7) begin
                vectors++;
                if (changed !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL simul_strobe E7 got chg=%b required 0", changed);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(8'h00);
        raw_in = 8'h0F;
        repeat (8) tick();
        raw_in = 8'h1F;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({clean_out, rise_pulse, fall_pulse, changed} !== 25'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_async got %h/%h/%h/%b required all zero",
                     clean_out, rise_pulse, fall_pulse, changed);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                miscompares++;
                $display("[TB] FAIL midreset_model E%0d got %h/%h/%h/%b required %h/%h/%h/%b", n,
                         clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
            end
            if (n == 5) begin
                vectors++;
                if (clean_out !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_early E5 got clean=%h required 00", clean_out);
                end
            end
            if (n == 6) begin
                vectors++;
                if ({clean_out, rise_pulse} !== {8'h1F, 8'h1F}) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_latency E6 got clean=%h rise=%h required 1F/1F",
                             clean_out, rise_pulse);
                end
            end
        end
    endtask

    task automatic test_random();
        int           hold [W];
        logic [W-1:0] r;
        r = 8'h00;
        for (int i = 0; i < W; i++) hold[i] = 0;
        do_reset(8'h00);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    r[i]    = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 7));
                end
                hold[i]--;
            end
            raw_in = r;
            tick();
            vectors++;
            if ({clean_out, rise_pulse, fall_pulse, changed} !== {exp_clean, exp_rise, exp_fall, exp_changed}) begin
                miscompares++;
                $display("[TB] FAIL random_model cyc%0d got %h/%h/%h/%b required %h/%h/%h/%b", c,
                         clean_out, rise_pulse, fall_pulse, changed, exp_clean, exp_rise, exp_fall, exp_changed);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset_n = 1'b0;
        raw_in  = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tmc_status_conditioner.md
# tmc_status_conditioner

Input conditioner for the eight external TMC status lines. It sits directly upstream of the Nios II input PIO and drives that PIO's 8-bit `in_port`. The raw asynchronous lines are synchronized into `clk`, debounced per bit, and presented as a clean, glitch-free level vector. The block also emits per-bit one-cycle rise/fall pulses and a summary change strobe for future interrupt/edge-capture use.

## Interface
- `WIDTH`, 8: number of status lines.
- `SYNC_STAGES`, 2: synchronizer flops per bit; legal range 2..4.
- `DEBOUNCE_CNT`, 1000: number of consecutive cycles a synchronized level must hold before it is accepted; legal range 1..2^CNT_W-1.
- `CNT_W`, 16: width of each per-bit debounce counter.
- `RESET_VALUE`, {WIDTH{1'b0}}: reset level of the synchronizer chain and `clean_out`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `raw_in`  in  WIDTH  external status lines, asynchronous to `clk`.
- `clean_out`  out  WIDTH  debounced level; connects to the PIO `in_port`.
- `rise_pulse`  out  WIDTH  one-cycle high per bit when `clean_out[i]` goes 0→1.
- `fall_pulse`  out  WIDTH  one-cycle high per bit when `clean_out[i]` goes 1→0.
- `changed`  out  1  OR of all `rise_pulse` and `fall_pulse` bits, registered coincident with them.

## Operation
- Every output and internal flop is a register cleared by `reset_n`.
- Reset values: synchronizer stages = `RESET_VALUE`; `clean_out` = `RESET_VALUE`; counters = 0; `rise_pulse`, `fall_pulse` and `changed` = 0.
- Synchronizer: per bit, a `SYNC_STAGES`-deep flop chain. `sync[i]` is the last stage. No logic is placed between stages.
- Debounce (independent per bit i), evaluated every clock:
  - If `sync[i] == clean_out[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i] == DEBOUNCE_CNT-1`: `clean_out[i]` <= `sync[i]`; `cnt[i]` <= 0; fire the matching pulse.
  - Else: `cnt[i]` <= `cnt[i]` + 1.
- The counter never wraps. It saturates by construction at `DEBOUNCE_CNT-1`.
- Any single cycle of `sync[i]` equal to `clean_out[i]` restarts qualification from 0. A glitch shorter than `DEBOUNCE_CNT` cycles never reaches `clean_out`.
- Pulses: `rise_pulse[i]` and `fall_pulse[i]` are high only in the cycle in which the new `clean_out[i]` value first appears. They are 0 otherwise and never both high for the same bit.
- Bits are fully independent. Any number of bits may update in the same cycle, and `changed` is a single strobe for that cycle.
- After reset, if `raw_in` differs from `RESET_VALUE`, the difference is qualified normally and produces the corresponding pulses.
- Reset asserted mid-qualification: all state returns to reset values immediately. Qualification restarts from 0 after release.

## Timing
- Define E1 as the first rising edge that samples a new `raw_in[i]` level into stage 1.
- `sync[i]` takes the new level at edge E(SYNC_STAGES).
- `clean_out[i]`, the matching pulse and `changed` take effect at edge E(SYNC_STAGES+DEBOUNCE_CNT), provided the level holds throughout.
- With `DEBOUNCE_CNT`=1, `clean_out` lags `sync` by exactly one cycle.
- Pulse width is exactly one `clk` cycle.
- The PIO registers `clean_out` once more, so the CPU-visible latency is one cycle more than the figure above.
- No combinational path exists from `raw_in` to any output.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_CNT`=4, `RESET_VALUE`=0.
- **Reset:** hold `reset_n`=0 with `raw_in`=8'hFF. Required: `clean_out`=8'h00, all pulses 0. After release, `clean_out`=8'hFF at E6, `rise_pulse`=8'hFF and `changed`=1 for exactly one cycle.
- **Clean step:** `raw_in[3]` 0→1 held. Required: `clean_out`=8'h08 at E6, `rise_pulse`=8'h08 for one cycle at E6. Then `raw_in[3]` 1→0 gives `fall_pulse`=8'h08 six edges later.
- **Glitch rejection:** `raw_in[5]` high for 3 cycles, then low. Required: `clean_out` stays 8'h00 and no pulses. A 4-cycle pulse instead must propagate.
- **Bounce restart:** `raw_in[0]` pattern 1,1,1,0,1,1,1,1. Required: `clean_out[0]` rises only 4 cycles after the final 0 has cleared the synchronizer.
- **Simultaneous:** start from `clean_out`=8'h0F and drive `raw_in`=8'hF0. Required: at one edge `clean_out`=8'hF0, `rise_pulse`=8'hF0, `fall_pulse`=8'h0F, and a single `changed` pulse.
- **Reset mid-operation:** assert `reset_n` after 2 qualifying cycles of a change. Required: outputs return to 0 asynchronously. After release with the input still held, the full 6-edge latency applies again.
